fila_bytes: RTL

- Byte queue directly downstream of the deserializer.
- Accepts each assembled byte through the deserializer's data_ready/ack handshake and stores it in a circular buffer.
- Hands bytes out in FIFO order on a consumer dequeue request.
- Back-pressure: when full it withholds ack, so the deserializer stalls and keeps status_out low until space frees.

---
 rtl/fila_bytes.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fila_bytes.sv
// Byte queue behind the deserializer: accepts bytes via a data_ready/ack
// handshake into a circular buffer and pops them in FIFO order on request.
module fila_bytes #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clock_100KHz,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       data_ready_in,
    output logic                       ack_out,
    input  logic                       dequeue_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH):0]     len_out,
    output logic                       full_out,
    output logic                       empty_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t           state, state_next;
    logic             ack_next;
    logic             do_wr;
    logic             do_rd;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    len;
    logic [WIDTH-1:0] mem [DEPTH];

    assign len_out   = len;
    assign full_out  = (len == LW'(DEPTH));
    assign empty_out = (len == '0);

    // A pop only needs a byte already stored; a same-cycle enqueue into an
    // empty queue is never bypassed to the output.
    assign do_rd = dequeue_in && !empty_out;

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Enqueue handshake: one write per data_ready pulse, ack held until
    // the deserializer lowers data_ready.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        ack_next   = 1'b0;
        do_wr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_ready_in && !full_out) begin
                    do_wr      = 1'b1;
                    ack_next   = 1'b1;
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (data_ready_in) begin
                    ack_next = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            ack_out <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len     <= '0;
        end else begin
            ack_out <= ack_next;
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   len <= len + LW'(1);
                2'b01:   len <= len - LW'(1);
                default: len <= len;
            endcase
        end
    end

    // NOTE: storage has no reset; contents are don't-care until written, and
    // leaving it out lets the array map onto plain RAM/flops without reset fan-out.
    always_ff @(posedge clock_100KHz) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= do_rd;
            if (do_rd) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

endmodule
